banked_memory: RTL and testbench

BANKED_MEMORY -- requirements
Module: banked_memory

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_rsp_fifo.sv | 61 ++++++
 rtl/banked_memory.sv | 118 +++++++++++
 tb/tb_banked_memory.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and response payload for the banked memory block.
package mem_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 48;
  localparam int DEF_RD_LAT = 2;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } mem_rsp_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_rsp_fifo.sv
// Response FIFO for completed reads; output is forced to zero while empty.
module mem_rsp_fifo
  import mem_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = mem_rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic not_empty,
  output T     pop_data
);
  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_push  = push && (cnt_q != CW'(DEPTH));
    do_pop   = pop && (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = inc(rd_ptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign not_empty = (cnt_q != '0);
  assign pop_data  = not_empty ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/banked_memory.sv
// Byte-enabled word memory with a fixed-latency read pipeline and
// credit-based flow control into an in-order response FIFO.
module banked_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int NBYTE  = DATA_W / 8;
  localparam int FIFO_D = RD_LAT + 1;
  localparam int CW     = clog2_min1(FIFO_D + 1);

  // Same layout as mem_rsp_t, sized to this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              ready_en_q, ready_en_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  rsp_t [RD_LAT-1:0] dat_pipe_q, dat_pipe_d;
  logic              rd_fire, wr_fire, in_range, pop, fifo_ne;
  logic [DATA_W-1:0] rd_word;
  rsp_t              rd_rsp, fifo_out;

  assign req_ready = ready_en_q && (credit_q < CW'(FIFO_D));
  assign rd_fire   = req_valid && req_ready && !req_wr;
  assign wr_fire   = req_valid && req_ready && req_wr;
  assign in_range  = {{(32-ADDR_W){1'b0}}, req_addr} < 32'(DEPTH);
  assign pop       = fifo_ne && rsp_ready;

  // Out-of-range addresses match no word, so writes to them fall away.
  always_comb begin
    rd_word = '0;
    mem_d   = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        rd_word = mem_q[i];
        if (wr_fire)
          for (int b = 0; b < NBYTE; b++)
            if (req_be[b]) mem_d[i][8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
    rd_rsp.rdata = in_range ? rd_word : '0;
    rd_rsp.err   = !in_range;
  end

  // Stage k holds a read accepted k+1 edges ago; the last stage feeds the FIFO.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '0;
    vld_pipe_d[0] = rd_fire;
    dat_pipe_d[0] = rd_rsp;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      dat_pipe_d[k] = dat_pipe_q[k-1];
    end
  end

  always_comb begin
    credit_d   = credit_q;
    ready_en_d = 1'b1;
    if (rd_fire && !pop)      credit_d = credit_q + CW'(1);
    else if (!rd_fire && pop) credit_d = credit_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ready_en_q <= 1'b0;
      credit_q   <= '0;
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      mem_q      <= mem_d;
      ready_en_q <= ready_en_d;
      credit_q   <= credit_d;
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  // Credit bounds pipeline + FIFO, so a push never meets a full FIFO.
  mem_rsp_fifo #(
    .DEPTH (FIFO_D),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe_q[RD_LAT-1]),
    .push_data (dat_pipe_q[RD_LAT-1]),
    .pop       (pop),
    .not_empty (fifo_ne),
    .pop_data  (fifo_out)
  );

  assign rsp_valid = fifo_ne;
  assign rsp_rdata = fifo_out.rdata;
  assign rsp_err   = fifo_out.err;
endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench: three instances (RD_LAT 2/1/4) exercised in turn.
module tb_banked_memory;
  import mem_pkg::*;

  localparam int NDUT  = 3;
  localparam int DEPTH = 48;
  localparam int LAT [NDUT] = '{2, 1, 4};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_wr, rsp_ready;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  int          cur;

  logic        req_valid_v [NDUT];
  logic        req_ready_v [NDUT];
  logic        rsp_valid_v [NDUT];
  logic        rsp_err_v   [NDUT];
  logic [31:0] rsp_rdata_v [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign req_valid_v[g] = req_valid && (cur == g);
    banked_memory #(
      .ADDR_W (6),
      .DEPTH  (DEPTH),
      .DATA_W (32),
      .RD_LAT (LAT[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid_v[g]),
      .req_ready (req_ready_v[g]),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid_v[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata_v[g]),
      .rsp_err   (rsp_err_v[g])
    );
  end

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;
  always_comb begin
    req_ready_m = req_ready_v[cur];
    rsp_valid_m = rsp_valid_v[cur];
    rsp_err_m   = rsp_err_v[cur];
    rsp_rdata_m = rsp_rdata_v[cur];
  end

  int          n_chk = 0;
  int          n_fail = 0;
  mem_rsp_t    exp_q [$];
  logic [31:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d): got %0h expected %0h", tag, LAT[cur], act, exp);
    end
  endtask

  // Response side: payload must match the queue head every cycle it is shown.
  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid_m) begin
        if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          chk("rsp_rdata", rsp_rdata_m, exp_q[0].rdata);
          chk("rsp_err", rsp_err_m, exp_q[0].err);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", {rsp_err_m, rsp_rdata_m}, 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    exp_q.delete();
  endtask

  task automatic push_rd(input int addr);
    mem_rsp_t e;
    e.err   = (addr >= DEPTH);
    e.rdata = '0;
    if (addr < DEPTH) e.rdata = mdl[addr];
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input int addr, input logic [31:0] wd, input logic [3:0] be);
    int w = 0;
    req_wr    = wr;
    req_addr  = 6'(addr);
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    while (!req_ready_m && w < 50) begin
      if (w == 8) rsp_ready = 1'b1;
      tick();
      w++;
    end
    if (!req_ready_m) chk("req_ready_timeout", 0, 1);
    else begin
      @(posedge clk);
      if (wr) begin
        if (addr < DEPTH)
          for (int b = 0; b < 4; b++)
            if (be[b]) mdl[addr][8*b +: 8] = wd[8*b +: 8];
      end else push_rd(addr);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain;
    int w = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    tick();
    chk("ready_after_drain", req_ready_m, 1);
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready_m, 0);
    chk("rst_rsp_valid", rsp_valid_m, 0);
    chk("rst_rsp_data", {rsp_err_m, rsp_rdata_m}, 0);
    mdl_clear();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
    chk("ready_after_rst", req_ready_m, 1);
  endtask

  task automatic run_suite;
    int lat;
    int n_acc;
    logic acc;
    do_reset();

    // basic write/read and latency
    rsp_ready = 1'b1;
    issue(1, 5, 32'hDEADBEEF, 4'hF);
    issue(0, 5, 0, 0);
    lat = 0;
    while (!rsp_valid_m && lat < 10) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, LAT[cur]);
    drain();

    // byte enables, including all-zero
    issue(1, 3, 32'hFFFFFFFF, 4'hF);
    issue(1, 3, 32'h00000000, 4'h5);
    issue(1, 4, 32'hFFFFFFFF, 4'hF);
    issue(1, 4, 32'h00000000, 4'h0);
    issue(0, 3, 0, 0);
    issue(0, 4, 0, 0);
    drain();

    // address range edges
    issue(1, 2, 32'h12345678, 4'hF);
    issue(1, 47, 32'hCAFEF00D, 4'hF);
    issue(0, 50, 0, 0);
    issue(1, 50, 32'hA5A5A5A5, 4'hF);
    issue(0, 2, 0, 0);
    issue(1, 63, 32'h5A5A5A5A, 4'hF);
    issue(0, 63, 0, 0);
    issue(0, 47, 0, 0);
    drain();

    // credit limit with consumer stalled
    for (int i = 0; i < 6; i++) issue(1, 10 + i, 32'h0100_0000 * (i + 1) + i, 4'hF);
    rsp_ready = 1'b0;
    n_acc     = 0;
    req_wr    = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < LAT[cur] + 4; c++) begin
      acc      = req_ready_m;
      req_addr = 6'(10 + n_acc);
      @(posedge clk);
      if (acc) begin
        push_rd(10 + n_acc);
        n_acc++;
      end
      #1;
    end
    req_valid = 1'b0;
    chk("credit_accepts", n_acc, LAT[cur] + 1);
    chk("credit_full_ready", req_ready_m, 0);
    drain();

    // random traffic with a bursty consumer
    for (int i = 0; i < 30; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 55), $urandom, 4'($urandom_range(0, 15)));
    end
    drain();

    // reset with reads in flight
    issue(1, 7, 32'h77777777, 4'hF);
    drain();
    rsp_ready = 1'b0;
    issue(0, 7, 0, 0);
    issue(0, 7, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid_m, 0);
    chk("rst_mid_req_ready", req_ready_m, 0);
    chk("rst_mid_rsp_data", {rsp_err_m, rsp_rdata_m}, 0);
    mdl_clear();
    repeat (2) @(posedge clk);
    #3;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    repeat (LAT[cur] + 4) tick();
    chk("no_rsp_after_rst", rsp_valid_m, 0);
    issue(0, 7, 0, 0);
    issue(0, 5, 0, 0);
    drain();
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    cur       = 0;
    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      run_suite();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
